// File: rtl/dma_reg_master_pkg.sv
// Shared types and default widths for the DMA register-port initiator.
package dma_reg_master_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 32;
    localparam int DMA_RD_LAT = 1;
    localparam int DMA_CNT_W  = 16;
    // Wide enough to count up to the largest legal read latency (4).
    localparam int DMA_LAT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RESP,
        ST_WR_VFY
    } dma_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [DMA_DATA_W-1:0] rdata;
        logic                  err;
    } dma_mst_rsp_t;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/dma_reg_master.sv
// Register-port initiator: one bus cycle per command; write rsp 1 cycle after accept, read rsp 1+RD_LAT.
// rsp held until rsp_ready, no new command meanwhile; DMA_REG_MASTER_WVERIFY_EN adds a write read-back check.
module dma_reg_master
    import dma_reg_master_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int RD_LAT = DMA_RD_LAT,
    parameter int CNT_W  = DMA_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  txn_count
);

    dma_mst_state_e       r_state;
    dma_mst_rsp_t         r_rsp;
    logic                 r_rsp_valid;
    logic                 r_wr_en;
    logic                 r_rd_en;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DMA_LAT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0]     r_txn_cnt;
`ifdef DMA_REG_MASTER_WVERIFY_EN
    logic [DATA_W-1:0]    r_cmd_wdata;
`endif
    logic                 w_cmd_fire;

    // Gated by rst_n so nothing is accepted while the block is held in reset.
    assign cmd_ready  = rst_n & (r_state == ST_IDLE);
    assign w_cmd_fire = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lat_cnt   <= '0;
            r_txn_cnt   <= '0;
`ifdef DMA_REG_MASTER_WVERIFY_EN
            r_cmd_wdata <= '0;
`endif
        end else begin
            if (r_wr_en | r_rd_en)
                r_txn_cnt <= r_txn_cnt + CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_rsp.write <= cmd_write;
                        if (is_misaligned(cmd_addr[1:0])) begin
                            r_rsp.err   <= 1'b1;
                            r_rsp.rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (cmd_write) begin
                            r_wr_en <= 1'b1;
                            r_addr  <= cmd_addr;
                            r_wdata <= cmd_wdata;
`ifdef DMA_REG_MASTER_WVERIFY_EN
                            r_cmd_wdata <= cmd_wdata;
`endif
                            r_state <= ST_WR;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_addr  <= cmd_addr;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    r_wr_en <= 1'b0;
                    r_wdata <= '0;
`ifdef DMA_REG_MASTER_WVERIFY_EN
                    // Address stays on the bus for the read-back strobe.
                    r_rd_en <= 1'b1;
                    r_state <= ST_WR_VFY;
`else
                    r_addr      <= '0;
                    r_rsp.err   <= 1'b0;
                    r_rsp.rdata <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
`endif
                end
                ST_RD, ST_WR_VFY: begin
                    r_rd_en   <= 1'b0;
                    r_addr    <= '0;
                    r_lat_cnt <= DMA_LAT_W'(1);
                    r_state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_lat_cnt == DMA_LAT_W'(RD_LAT)) begin
                        r_rsp.rdata <= DMA_DATA_W'(rdata);
`ifdef DMA_REG_MASTER_WVERIFY_EN
                        r_rsp.err   <= r_rsp.write & (rdata != r_cmd_wdata);
`else
                        r_rsp.err   <= 1'b0;
`endif
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + DMA_LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp.write;
    assign rsp_rdata = DATA_W'(r_rsp.rdata);
    assign rsp_err   = r_rsp.err;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign txn_count = r_txn_cnt;

endmodule

// File: tb/tb_dma_reg_master.sv
// Scoreboard bench: lane 0 runs RD_LAT=1/CNT_W=16, lane 1 runs RD_LAT=3/CNT_W=4 (fast counter wrap).
module tb_dma_reg_master;

`ifdef DMA_REG_MASTER_WVERIFY_EN
    localparam int VFY = 1;
    localparam logic [31:0] WMASK = 32'hFFFF_FFFE;
`else
    localparam int VFY = 0;
    localparam logic [31:0] WMASK = 32'hFFFF_FFFF;
`endif

    typedef struct {
        bit          write;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          acc;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_write [2];
    logic [31:0] cmd_addr  [2];
    logic [31:0] cmd_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2] = '{1'b1, 1'b1};
    logic        rsp_write [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        wr_en     [2];
    logic        rd_en     [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic [15:0] txn_count [2];
    logic [3:0]  tc1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cnt_m [2] = '{0, 0};
    int hold_req [2] = '{0, 0};
    int fire_cyc [2] = '{0, 0};

    exp_t q0[$];
    exp_t q1[$];
    bus_t bq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_reg_master #(.RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .txn_count(txn_count[0])
    );

    dma_reg_master #(.RD_LAT(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .txn_count(tc1)
    );
    assign txn_count[1] = {12'h000, tc1};

    // Register bank models: read data appears RD_LAT edges after the edge sampling rd_en.
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    logic [31:0] rp0;
    logic [31:0] rp1 [3];

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (wr_en[0]) mem0[addr[0][6:2]] <= wdata[0] & WMASK;
        rp0 <= rd_en[0] ? mem0[addr[0][6:2]] : 32'h0;
        if (wr_en[1]) mem1[addr[1][6:2]] <= wdata[1] & WMASK;
        rp1[0] <= rd_en[1] ? mem1[addr[1][6:2]] : 32'h0;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign rdata[0] = rp0;
    assign rdata[1] = rp1[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input int l, input string tag);
        chk($sformatf("%s_cmd_ready[%0d]", tag, l), 64'(cmd_ready[l]), 64'h0);
        chk($sformatf("%s_rsp_valid[%0d]", tag, l), 64'(rsp_valid[l]), 64'h0);
        chk($sformatf("%s_rsp_write[%0d]", tag, l), 64'(rsp_write[l]), 64'h0);
        chk($sformatf("%s_rsp_err[%0d]", tag, l), 64'(rsp_err[l]), 64'h0);
        chk($sformatf("%s_rsp_rdata[%0d]", tag, l), 64'(rsp_rdata[l]), 64'h0);
        chk($sformatf("%s_strobes[%0d]", tag, l), 64'({wr_en[l], rd_en[l]}), 64'h0);
        chk($sformatf("%s_addr[%0d]", tag, l), 64'(addr[l]), 64'h0);
        chk($sformatf("%s_wdata[%0d]", tag, l), 64'(wdata[l]), 64'h0);
        chk($sformatf("%s_txn_count[%0d]", tag, l), 64'(txn_count[l]), 64'h0);
    endtask

    // Issues one command; expected response/bus entries are queued at the handshake.
    task automatic send(input int l, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input bit eerr, input bit track, output int acc);
        exp_t e;
        bus_t b;
        bit   ok = 1'b0;
        bit   mis;
        int   lt;
        int   lat = (l == 0) ? 1 : 3;
        int   cmask = (l == 0) ? 32'hFFFF : 32'h000F;
        @(negedge clk);
        cmd_valid[l] = 1'b1;
        cmd_write[l] = w;
        cmd_addr[l]  = a;
        cmd_wdata[l] = d;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready[l]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        acc = cyc + 1;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL cmd_accept[%0d]: cmd_ready never high in 200 cycles, expected accept", l);
            cmd_valid[l] = 1'b0;
            return;
        end
        mis = (a[1:0] != 2'b00);
        lt  = mis ? 0 : (w ? 1 + VFY * (1 + lat) : 1 + lat);
        if (!mis) cnt_m[l] = (cnt_m[l] + (w ? 1 + VFY : 1)) & cmask;
        e = '{w, erd, eerr, lt, acc, 16'(cnt_m[l])};
        if (track) begin
            if (l == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (l == 0 && !mis) begin
            b = '{w, a, d};
            bq.push_back(b);
            if (w && VFY == 1) begin
                b = '{1'b0, a, 32'h0};
                bq.push_back(b);
            end
        end
        @(posedge clk);
        #1 cmd_valid[l] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("drain_q0_pending", 64'(q0.size()), 64'h0);
        chk("drain_q1_pending", 64'(q1.size()), 64'h0);
        chk("drain_bus_pending", 64'(bq.size()), 64'h0);
    endtask

    // Response monitor: stability during stall, cmd_ready low, then scoreboard compare on fire.
    bit          started   [2] = '{1'b0, 1'b0};
    int          start_cyc [2];
    int          stall     [2];
    logic [33:0] held      [2];

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!rst_n) begin
                started[l]   = 1'b0;
                rsp_ready[l] = 1'b1;
            end else if (rsp_valid[l]) begin
                logic [33:0] cur;
                exp_t        e;
                cur = {rsp_write[l], rsp_rdata[l], rsp_err[l]};
                if (!started[l]) begin
                    started[l]   = 1'b1;
                    start_cyc[l] = cyc;
                    held[l]      = cur;
                    stall[l]     = hold_req[l];
                end else begin
                    chk($sformatf("rsp_stable[%0d]", l), 64'(cur), 64'(held[l]));
                end
                chk($sformatf("cmd_ready_in_resp[%0d]", l), 64'(cmd_ready[l]), 64'h0);
                rsp_ready[l] = (stall[l] == 0);
                if (stall[l] > 0) stall[l]--;
                if (rsp_ready[l]) begin
                    started[l]  = 1'b0;
                    fire_cyc[l] = cyc + 1;
                    if ((l == 0 ? q0.size() : q1.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected[%0d]: got response 0x%0h, expected none", l, cur);
                    end else begin
                        e = (l == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rsp_write[%0d]", l), 64'(rsp_write[l]), 64'(e.write));
                        chk($sformatf("rsp_rdata[%0d]", l), 64'(rsp_rdata[l]), 64'(e.rdata));
                        chk($sformatf("rsp_err[%0d]", l), 64'(rsp_err[l]), 64'(e.err));
                        chk($sformatf("rsp_latency[%0d]", l), 64'(start_cyc[l] - e.acc), 64'(e.lat));
                        chk($sformatf("txn_count[%0d]", l), 64'(txn_count[l]), 64'(e.cnt));
                    end
                end
            end else begin
                rsp_ready[l] = 1'b1;
            end
        end
    end

    // Lane 0 bus monitor: exclusive one-cycle strobes, idle bus zero, contents match queue.
    always @(negedge clk) begin
        if (rst_n) begin
            bus_t b;
            tests++;
            if ((wr_en[0] && rd_en[0]) ||
                (!wr_en[0] && !rd_en[0] && (addr[0] != 32'h0 || wdata[0] != 32'h0))) begin
                fails++;
                $display("FAIL bus_rules: wr_en=%b rd_en=%b addr=0x%0h wdata=0x%0h, expected exclusive strobes and zero idle bus",
                         wr_en[0], rd_en[0], addr[0], wdata[0]);
            end
            if (wr_en[0] || rd_en[0]) begin
                if (bq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: wr_en=%b rd_en=%b addr=0x%0h, expected no strobe",
                             wr_en[0], rd_en[0], addr[0]);
                end else begin
                    b = bq.pop_front();
                    chk("bus_wr_en", 64'(wr_en[0]), 64'(b.w));
                    chk("bus_addr", 64'(addr[0]), 64'(b.a));
                    if (b.w) chk("bus_wdata", 64'(wdata[0]), 64'(b.d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            cmd_valid[l] = 1'b0;
            cmd_write[l] = 1'b0;
            cmd_addr[l]  = 32'h0;
            cmd_wdata[l] = 32'h0;
        end
        #12;
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lane 0: write, read back, misaligned read.
        send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, VFY ? 32'hDEAD_BEEE : 32'h0, VFY == 1, 1'b1, acc);
        send(0, 1'b0, 32'h10, 32'h0, VFY ? 32'hDEAD_BEEE : 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
        send(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1, acc);

        // Backpressure: response stalled 5 cycles with the next command waiting.
        hold_req[0] = 5;
        send(0, 1'b1, 32'h20, 32'h1234_5678, VFY ? 32'h1234_5678 : 32'h0, 1'b0, 1'b1, acc);
        send(0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 1'b1, acc);
        hold_req[0] = 0;
        chk("bp_accept_after_fire", 64'(acc), 64'(fire_cyc[0] + 1));

        // Bit 0 is the one the bank drops when read-back checking is compiled in.
        send(0, 1'b1, 32'h24, 32'h0000_0001, 32'h0, VFY == 1, 1'b1, acc);
        send(0, 1'b0, 32'h24, 32'h0, VFY ? 32'h0 : 32'h1, 1'b0, 1'b1, acc);
        send(0, 1'b1, 32'h00, 32'hA5A5_A5A4, VFY ? 32'hA5A5_A5A4 : 32'h0, 1'b0, 1'b1, acc);
        send(0, 1'b0, 32'h00, 32'h0, 32'hA5A5_A5A4, 1'b0, 1'b1, acc);
        send(0, 1'b1, 32'h02, 32'h0000_FFFF, 32'h0, 1'b1, 1'b1, acc);
        drain();

        // Lane 1: longer read latency, then enough writes to wrap the 4-bit counter.
        send(1, 1'b1, 32'h10, 32'hCAFE_F00D, VFY ? 32'hCAFE_F00C : 32'h0, VFY == 1, 1'b1, acc);
        send(1, 1'b0, 32'h10, 32'h0, VFY ? 32'hCAFE_F00C : 32'hCAFE_F00D, 1'b0, 1'b1, acc);
        for (int i = 0; i < 14; i++) begin
            logic [31:0] d = 32'(i);
            send(1, 1'b1, 32'h40 + 32'(i * 4), d, VFY ? (d & WMASK) : 32'h0,
                 (VFY == 1) && d[0], 1'b1, acc);
        end
        drain();

        // Reset while lane 1 sits in its read-latency wait.
        send(1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(1, "midreset");
        chk_zero(0, "midreset");
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_quiet[1]", 64'({rsp_valid[1], wr_en[1], rd_en[1]}), 64'h0);
        end
        send(1, 1'b1, 32'h30, 32'h0000_0055, VFY ? 32'h0000_0054 : 32'h0, VFY == 1, 1'b1, acc);
        send(0, 1'b0, 32'h24, 32'h0, VFY ? 32'h0 : 32'h1, 1'b0, 1'b1, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
